// File: rtl/radix4_div_pkg.sv
// rtl/radix4_div_pkg.sv - shared types and constants for the radix-4 divider
// Build option: RADIX4_DIVIDER_SIGNED_EN selects two's complement operands.
package radix4_div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_e;

    localparam int DIGIT_W = 2;

    function automatic int iter_count(input int width);
        return width / DIGIT_W;
    endfunction

endpackage

// File: rtl/radix4_qsel.sv
// rtl/radix4_qsel.sv - radix-4 restoring digit select: largest q*D <= P, q in 0..3
module radix4_qsel
    import radix4_div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH+1:0]   p_i,
    input  logic [WIDTH+1:0]   d_i,
    input  logic [WIDTH+1:0]   d2_i,
    input  logic [WIDTH+1:0]   d3_i,
    output logic [DIGIT_W-1:0] q_o,
    output logic [WIDTH+1:0]   r_o
);

    // P < 4D always holds, so the three compares fully cover the digit range.
    always_comb begin
        q_o = 2'd0;
        r_o = p_i;
        if (p_i >= d3_i) begin
            q_o = 2'd3;
            r_o = p_i - d3_i;
        end else if (p_i >= d2_i) begin
            q_o = 2'd2;
            r_o = p_i - d2_i;
        end else if (p_i >= d_i) begin
            q_o = 2'd1;
            r_o = p_i - d_i;
        end
    end

endmodule

// File: rtl/radix4_divider.sv
// rtl/radix4_divider.sv - sequential radix-4 restoring divider, 2 quotient bits per clock
// Build option: RADIX4_DIVIDER_SIGNED_EN enables two's complement operands (truncating division).
module radix4_divider
    import radix4_div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int ITERS  = iter_count(WIDTH);
    localparam int ITER_W = $clog2(ITERS);

    state_e              state_q;
    logic [ITER_W-1:0]   iter_q;
    logic [WIDTH-1:0]    dvd_q;
    logic [WIDTH+1:0]    dsr_q;
    logic [WIDTH+1:0]    dsr3_q;
    logic [WIDTH+1:0]    rem_q;
    logic [WIDTH-1:0]    quo_q;
    logic                busy_q;
    logic                done_q;
    logic [WIDTH-1:0]    quotient_q;
    logic [WIDTH-1:0]    remainder_q;
    logic                dbz_q;

    logic [WIDTH-1:0]    dvd_abs;
    logic [WIDTH-1:0]    dsr_abs;
    logic [WIDTH+1:0]    p_w;
    logic [WIDTH+1:0]    dsr2_w;
    logic [DIGIT_W-1:0]  q_sel;
    logic [WIDTH+1:0]    r_sel;
    logic [WIDTH-1:0]    quo_d;
    logic [WIDTH-1:0]    quo_res;
    logic [WIDTH-1:0]    rem_res;

`ifdef RADIX4_DIVIDER_SIGNED_EN
    logic neg_q_d, neg_r_d;
    logic neg_q_q, neg_r_q;

    always_comb begin
        neg_r_d = dividend[WIDTH-1];
        neg_q_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
        dvd_abs = dividend[WIDTH-1] ? -dividend : dividend;
        dsr_abs = divisor[WIDTH-1]  ? -divisor  : divisor;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
        end
    end

    // Remainder follows the dividend sign so the quotient truncates toward zero.
    always_comb begin
        quo_res = quo_d;
        rem_res = WIDTH'(r_sel);
        if (neg_q_q) quo_res = -quo_d;
        if (neg_r_q) rem_res = -rem_res;
    end
`else
    assign dvd_abs = dividend;
    assign dsr_abs = divisor;

    always_comb begin
        quo_res = quo_d;
        rem_res = WIDTH'(r_sel);
    end
`endif

    // Partial remainder shifted left by one digit with the next two dividend MSBs appended.
    assign p_w    = (WIDTH+2)'({rem_q, dvd_q[WIDTH-1 -: DIGIT_W]});
    assign dsr2_w = dsr_q << 1;
    assign quo_d  = WIDTH'({quo_q, q_sel});

    radix4_qsel #(
        .WIDTH (WIDTH)
    ) u_qsel (
        .p_i  (p_w),
        .d_i  (dsr_q),
        .d2_i (dsr2_w),
        .d3_i (dsr3_q),
        .q_o  (q_sel),
        .r_o  (r_sel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            iter_q      <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            dsr3_q      <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dvd_q  <= dvd_abs;
                        dsr_q  <= {2'b00, dsr_abs};
                        dsr3_q <= {2'b00, dsr_abs} + {1'b0, dsr_abs, 1'b0};
                        rem_q  <= '0;
                        quo_q  <= '0;
                        iter_q <= ITER_W'(ITERS - 1);
                        dbz_q  <= 1'b0;
                        if (divisor == '0) begin
                            state_q     <= FINISH;
                            done_q      <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                        end else begin
                            state_q <= CALC;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    dvd_q  <= dvd_q << DIGIT_W;
                    rem_q  <= r_sel;
                    quo_q  <= quo_d;
                    iter_q <= iter_q - ITER_W'(1);
                    // Results load on the edge that enters FINISH so they are valid with done.
                    if (iter_q == '0) begin
                        state_q     <= FINISH;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        quotient_q  <= quo_res;
                        remainder_q <= rem_res;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
